// File: rtl/ccff_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
package ccff_loader_pkg;

    localparam int unsigned DEF_WORD_W    = 8;
    localparam int unsigned DEF_CHAIN_LEN = 1024;
    localparam int unsigned DEF_STALL_MAX = 255;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/ccff_stall_timer.sv
// Counts FETCH cycles spent waiting for a bitstream word.
module ccff_stall_timer #(
    parameter int unsigned MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_max
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !at_max) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High when one more counted cycle brings the total to MAX.
    assign at_max = (cnt_q == CW'(MAX - 1));

endmodule

// File: rtl/ccff_loader.sv
// Streams bitstream words LSB-first into the fabric configuration chain.
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int unsigned STALL_MAX = DEF_STALL_MAX
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              tmr_clr, tmr_en, tmr_max;
    logic              last_bit, chain_last;

    assign last_bit   = (bit_idx_q == IDX_W'(WORD_W - 1));
    assign chain_last = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));

    ccff_stall_timer #(
        .MAX (STALL_MAX)
    ) u_stall_timer (
        .clk    (prog_clk),
        .rst    (prog_reset),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .at_max (tmr_max)
    );

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            sreg_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            sreg_q    <= sreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        sreg_d     = sreg_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        word_ready = 1'b0;
        ccff_head  = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                done = (state_q == StDone);
                err  = (state_q == StErr);
                if (start) begin
                    state_d   = StFetch;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    tmr_clr   = 1'b1;
                end
            end
            StFetch: begin
                busy       = 1'b1;
                word_ready = 1'b1;
                if (word_valid) begin
                    state_d   = StShift;
                    sreg_d    = word_data;
                    bit_idx_d = '0;
                    tmr_clr   = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_max) begin
                        state_d = StErr;
                    end
                end
            end
            StShift: begin
                busy       = 1'b1;
                shift_en   = 1'b1;
                ccff_head  = sreg_q[0];
                // Refill on the last bit so consecutive words shift without a bubble.
                word_ready = last_bit && !chain_last;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                bit_idx_d  = bit_idx_q + 1'b1;
                sreg_d     = sreg_q >> 1;
                if (chain_last) begin
                    state_d = StDone;
                end else if (last_bit) begin
                    bit_idx_d = '0;
                    if (word_valid) begin
                        sreg_d  = word_data;
                        tmr_clr = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
